// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants.
// Used by the instruction prefetch buffer and its FIFO.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  typedef enum logic {
    RUN,
    DRAIN
  } pf_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with clear priority and read-before-write.
// rdata is the head word, valid whenever count is non-zero.
module sync_fifo #(
  parameter  int N     = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [N-1:0]  wdata,
  output logic [N-1:0]  rdata,
  output logic [CW-1:0] count
);

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;

  assign rdata = mem[rd_ptr];
  assign count = cnt;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // head is read combinationally, so a full push+pop overwrites it safely
  always_ff @(posedge clk) begin
    if (reset && !clear && push)
      mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/inst_prefetch_buf.sv
// Instruction prefetch queue between instruction memory and IF.
// Issues sequential fetches on credit; redirect flushes and refetches.
module inst_prefetch_buf
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        req_valid,
  output logic [31:0] req_addr,
  input  logic        req_ready,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc_plus4,
  input  logic        take
);

  localparam int CW = $clog2(DEPTH) + 1;

  pf_state_t     state, state_n;
  logic [31:0]   fetch_pc, fetch_pc_n;
  logic [31:0]   out_pc, out_pc_n;
  logic [CW-1:0] outstanding, outstanding_n;
  logic [CW-1:0] drop_cnt, drop_cnt_n;
  logic [CW-1:0] count;
  logic [CW:0]   used;
  logic [31:0]   head;
  logic          hs;
  logic          push;
  logic          pop;

  assign used       = {1'b0, count} + {1'b0, outstanding};
  assign req_valid  = reset && !redirect && (used < (CW+1)'(DEPTH));
  assign req_addr   = fetch_pc;
  assign hs         = req_valid && req_ready;
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && take && !redirect;
  assign push       = resp_valid && (state == RUN) && !redirect;
  assign inst       = inst_valid ? head : NOP;
  assign pc_plus4   = out_pc + 32'd4;

  sync_fifo #(
    .N     (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (redirect),
    .push  (push),
    .pop   (pop),
    .wdata (resp_data),
    .rdata (head),
    .count (count)
  );

  always_comb begin
    fetch_pc_n    = fetch_pc;
    out_pc_n      = out_pc;
    drop_cnt_n    = drop_cnt;
    outstanding_n = outstanding + CW'(hs) - CW'(resp_valid);
    if (redirect) begin
      fetch_pc_n = redirect_pc;
      out_pc_n   = redirect_pc;
      // every request still in flight is stale; already-counted
      // stale ones are a subset of outstanding, so no double count
      drop_cnt_n = outstanding - CW'(resp_valid);
    end else begin
      if (hs)  fetch_pc_n = fetch_pc + 32'd4;
      if (pop) out_pc_n   = out_pc + 32'd4;
      unique case (state)
        RUN:   drop_cnt_n = drop_cnt;
        DRAIN: if (resp_valid) drop_cnt_n = drop_cnt - CW'(1);
        default: drop_cnt_n = drop_cnt;
      endcase
    end
    state_n = (drop_cnt_n != '0) ? DRAIN : RUN;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      out_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      out_pc      <= out_pc_n;
      outstanding <= outstanding_n;
      drop_cnt    <= drop_cnt_n;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!reset)
    !(push && !pop && count == CW'(DEPTH))
  );

endmodule
